// File: rtl/frame_buffer_scheduler.sv
// Frame lifecycle sequencer (clear -> capture -> ready) and sole owner of the
// single-port 28x28 pixel BRAM, arbitrating clear, capture writes and readout.
module frame_buffer_scheduler #(
   parameter int DEPTH  = 784,
   parameter int ADDR_W = 10,
   parameter int DATA_W = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              take_photo,
   input  logic              frame_done,
   output logic              busy,
   output logic              frame_ready,
   input  logic              cap_wr_valid,
   input  logic [ADDR_W-1:0] cap_wr_addr,
   input  logic [DATA_W-1:0] cap_wr_data,
   output logic              cap_wr_ready,
   input  logic              rd_req_valid,
   input  logic [ADDR_W-1:0] rd_req_addr,
   output logic              rd_req_ready,
   output logic              rd_rsp_valid,
   output logic [DATA_W-1:0] rd_rsp_data,
   output logic [7:0]        oob_count,
   output logic              bram_en,
   output logic              bram_we,
   output logic [ADDR_W-1:0] bram_addr,
   output logic [DATA_W-1:0] bram_din,
   input  logic [DATA_W-1:0] bram_dout
);

   typedef enum logic [1:0] {IDLE, CLEAR, CAPTURE, READY} state_t;

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

   state_t            state;
   logic              take_photo_q;
   logic [ADDR_W-1:0] clear_addr;
   logic              rd_p1, rd_p2;
   logic              rd_oob1, rd_oob2;

   logic photo_edge;
   logic cap_fire, rd_fire;
   logic cap_in_range, rd_in_range;

   assign photo_edge   = take_photo & ~take_photo_q;
   assign cap_fire     = cap_wr_valid & cap_wr_ready;
   assign rd_fire      = rd_req_valid & rd_req_ready;
   assign cap_in_range = (cap_wr_addr <= LAST_ADDR);
   assign rd_in_range  = (rd_req_addr <= LAST_ADDR);

   // Readies are gated by rst_n so they read 0 while reset is held, even though IDLE grants reads.
   // NOTE: every signal assigned in always_comb gets a default first, otherwise a latch is inferred.
   always_comb begin
      cap_wr_ready = 1'b0;
      rd_req_ready = 1'b0;
      if (rst_n) begin
         case (state)
            CAPTURE: begin
               cap_wr_ready = 1'b1;
               rd_req_ready = ~cap_wr_valid;
            end
            IDLE, READY: rd_req_ready = 1'b1;
            default: ;
         endcase
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         take_photo_q <= 1'b0;
         clear_addr   <= '0;
         busy         <= 1'b0;
         frame_ready  <= 1'b0;
         oob_count    <= '0;
         bram_en      <= 1'b0;
         bram_we      <= 1'b0;
         bram_addr    <= '0;
         bram_din     <= '0;
         rd_p1        <= 1'b0;
         rd_p2        <= 1'b0;
         rd_oob1      <= 1'b0;
         rd_oob2      <= 1'b0;
         rd_rsp_valid <= 1'b0;
         rd_rsp_data  <= '0;
      end else begin
         take_photo_q <= take_photo;
         bram_en      <= 1'b0;
         bram_we      <= 1'b0;

         // Read response pipeline runs regardless of state so in-flight reads always complete.
         rd_p1        <= rd_fire;
         rd_oob1      <= ~rd_in_range;
         rd_p2        <= rd_p1;
         rd_oob2      <= rd_oob1;
         rd_rsp_valid <= rd_p2;
         rd_rsp_data  <= (rd_p2 && !rd_oob2) ? bram_dout : '0;

         case (state)
            IDLE, READY: begin
               if (photo_edge) begin
                  state       <= CLEAR;
                  clear_addr  <= '0;
                  busy        <= 1'b1;
                  frame_ready <= 1'b0;
                  oob_count   <= '0;
               end
            end
            CLEAR: begin
               bram_en    <= 1'b1;
               bram_we    <= 1'b1;
               bram_addr  <= clear_addr;
               bram_din   <= '0;
               clear_addr <= clear_addr + 1'b1;
               if (clear_addr == LAST_ADDR) state <= CAPTURE;
            end
            CAPTURE: begin
               if (frame_done) begin
                  state       <= READY;
                  busy        <= 1'b0;
                  frame_ready <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase

         // Ready logic makes these mutually exclusive with CLEAR and with each other.
         if (cap_fire) begin
            if (cap_in_range) begin
               bram_en   <= 1'b1;
               bram_we   <= 1'b1;
               bram_addr <= cap_wr_addr;
               bram_din  <= cap_wr_data;
            end else if (oob_count != 8'hFF) begin
               oob_count <= oob_count + 8'd1;
            end
         end else if (rd_fire && rd_in_range) begin
            bram_en   <= 1'b1;
            bram_addr <= rd_req_addr;
         end
      end
   end

endmodule

// File: tb/tb_frame_buffer_scheduler.sv
// Self-checking bench for frame_buffer_scheduler: a behavioural BRAM plus a
// frame-content reference model driven by randomized and directed stimulus.
module tb_frame_buffer_scheduler;

   localparam int DEPTH = 784;
   localparam int AW    = 10;
   localparam int DW    = 16;

   logic          clk;
   logic          rst_n;
   logic          take_photo;
   logic          frame_done;
   logic          busy;
   logic          frame_ready;
   logic          cap_wr_valid;
   logic [AW-1:0] cap_wr_addr;
   logic [DW-1:0] cap_wr_data;
   logic          cap_wr_ready;
   logic          rd_req_valid;
   logic [AW-1:0] rd_req_addr;
   logic          rd_req_ready;
   logic          rd_rsp_valid;
   logic [DW-1:0] rd_rsp_data;
   logic [7:0]    oob_count;
   logic          bram_en;
   logic          bram_we;
   logic [AW-1:0] bram_addr;
   logic [DW-1:0] bram_din;
   logic [DW-1:0] bram_dout;

   int total;
   int bad;

   logic [DW-1:0] mem [0:1023];
   logic [DW-1:0] exp_frame [0:DEPTH-1];

   frame_buffer_scheduler #(.DEPTH(DEPTH), .ADDR_W(AW), .DATA_W(DW)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .take_photo   (take_photo),
      .frame_done   (frame_done),
      .busy         (busy),
      .frame_ready  (frame_ready),
      .cap_wr_valid (cap_wr_valid),
      .cap_wr_addr  (cap_wr_addr),
      .cap_wr_data  (cap_wr_data),
      .cap_wr_ready (cap_wr_ready),
      .rd_req_valid (rd_req_valid),
      .rd_req_addr  (rd_req_addr),
      .rd_req_ready (rd_req_ready),
      .rd_rsp_valid (rd_rsp_valid),
      .rd_rsp_data  (rd_rsp_data),
      .oob_count    (oob_count),
      .bram_en      (bram_en),
      .bram_we      (bram_we),
      .bram_addr    (bram_addr),
      .bram_din     (bram_din),
      .bram_dout    (bram_dout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single-port BRAM: dout valid one cycle after an enabled read.
   initial begin
      for (int i = 0; i < 1024; i++) mem[i] = DW'($urandom);
      bram_dout = '0;
   end
   always @(posedge clk) begin
      if (bram_en) begin
         if (bram_we) mem[bram_addr] <= bram_din;
         else bram_dout <= mem[bram_addr];
      end
   end

   // Any enabled BRAM cycle must target a valid pixel address.
   always @(negedge clk) begin
      if (rst_n && bram_en) begin
         total++;
         if (int'(bram_addr) >= DEPTH) begin
            bad++; $display("FAIL bram_addr_range: got %0d want <%0d", bram_addr, DEPTH);
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("test done: total=%0d bad=%0d", total, bad + 1);
      $fatal(1, "watchdog");
   end

   task automatic test_reset();
      rst_n = 1'b1; take_photo = 1'b0; frame_done = 1'b0;
      cap_wr_valid = 1'b0; cap_wr_addr = '0; cap_wr_data = '0;
      rd_req_valid = 1'b0; rd_req_addr = '0;
      #3 rst_n = 1'b0;
      #1;
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b want 0", busy); end
      total++; if (frame_ready !== 1'b0) begin bad++; $display("FAIL rst_frame_ready: got %b want 0", frame_ready); end
      total++; if (cap_wr_ready !== 1'b0) begin bad++; $display("FAIL rst_cap_wr_ready: got %b want 0", cap_wr_ready); end
      total++; if (rd_req_ready !== 1'b0) begin bad++; $display("FAIL rst_rd_req_ready: got %b want 0", rd_req_ready); end
      total++; if ({rd_rsp_valid, bram_en, bram_we} !== 3'b000) begin bad++; $display("FAIL rst_valid_en_we: got %b want 000", {rd_rsp_valid, bram_en, bram_we}); end
      total++; if ({bram_addr, bram_din, rd_rsp_data, oob_count} !== '0) begin bad++; $display("FAIL rst_data: addr=%0d din=%h rsp=%h oob=%0d want all 0", bram_addr, bram_din, rd_rsp_data, oob_count); end
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      total++; if (rd_req_ready !== 1'b1) begin bad++; $display("FAIL idle_rd_req_ready: got %b want 1", rd_req_ready); end
      total++; if ({busy, cap_wr_ready, bram_en} !== 3'b000) begin bad++; $display("FAIL idle_outputs: got %b want 000", {busy, cap_wr_ready, bram_en}); end
   endtask

   // Follows the clear engine from address first to last, one write per cycle.
   task automatic follow_clear(input int first, input int last, input bit glitch);
      for (int k = first; k <= last; k++) begin
         @(negedge clk);
         total++;
         if (!(bram_en === 1'b1 && bram_we === 1'b1 && int'(bram_addr) == k && bram_din === '0)) begin
            bad++; $display("FAIL clear_write: got en=%b we=%b addr=%0d din=%h want 1 1 %0d 0", bram_en, bram_we, bram_addr, bram_din, k);
         end
         total++;
         if (cap_wr_ready !== (k == DEPTH - 1)) begin
            bad++; $display("FAIL clear_cap_ready: at addr %0d got %b want %b", k, cap_wr_ready, (k == DEPTH - 1));
         end
         if (glitch && k == 200) take_photo = 1'b0;
         if (glitch && k == 300) take_photo = 1'b1;
      end
   endtask

   task automatic test_clear();
      @(negedge clk);
      take_photo = 1'b1;
      @(posedge clk);
      @(negedge clk);
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL clear_busy: got %b want 1", busy); end
      total++; if ({bram_we, cap_wr_ready, rd_req_ready} !== 3'b000) begin bad++; $display("FAIL clear_first_cycle: got we/cap/rd=%b want 000", {bram_we, cap_wr_ready, rd_req_ready}); end
      follow_clear(0, DEPTH - 1, 1'b1);
      @(negedge clk);
      total++; if (bram_we !== 1'b0) begin bad++; $display("FAIL clear_end_we: got %b want 0", bram_we); end
      total++; if ({busy, cap_wr_ready, frame_ready} !== 3'b110) begin bad++; $display("FAIL capture_entry: got busy/cap/ready=%b want 110", {busy, cap_wr_ready, frame_ready}); end
      take_photo = 1'b0;
      for (int i = 0; i < DEPTH; i++) exp_frame[i] = '0;
   endtask

   task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input bit fd);
      @(negedge clk);
      cap_wr_valid = 1'b1; cap_wr_addr = a; cap_wr_data = d; frame_done = fd;
      #1;
      total++; if (cap_wr_ready !== 1'b1) begin bad++; $display("FAIL wr_ready: addr %0d got %b want 1", a, cap_wr_ready); end
      @(posedge clk);
      if (int'(a) < DEPTH) exp_frame[a] = d;
      @(negedge clk);
      total++;
      if (int'(a) < DEPTH) begin
         if (!(bram_en === 1'b1 && bram_we === 1'b1 && bram_addr === a && bram_din === d)) begin
            bad++; $display("FAIL wr_bram: got en=%b we=%b addr=%0d din=%h want 1 1 %0d %h", bram_en, bram_we, bram_addr, bram_din, a, d);
         end
      end else if (bram_en !== 1'b0) begin
         bad++; $display("FAIL wr_oob_bram: got en=%b want 0", bram_en);
      end
      cap_wr_valid = 1'b0; frame_done = 1'b0;
   endtask

   task automatic do_read(input logic [AW-1:0] a, input logic [DW-1:0] expv);
      @(negedge clk);
      rd_req_valid = 1'b1; rd_req_addr = a;
      #1;
      total++; if (rd_req_ready !== 1'b1) begin bad++; $display("FAIL rd_ready: addr %0d got %b want 1", a, rd_req_ready); end
      @(posedge clk);
      @(negedge clk);
      rd_req_valid = 1'b0;
      total++; if (rd_rsp_valid !== 1'b0) begin bad++; $display("FAIL rd_early1: addr %0d got valid %b want 0", a, rd_rsp_valid); end
      @(negedge clk);
      total++; if (rd_rsp_valid !== 1'b0) begin bad++; $display("FAIL rd_early2: addr %0d got valid %b want 0", a, rd_rsp_valid); end
      @(negedge clk);
      total++;
      if (!(rd_rsp_valid === 1'b1 && rd_rsp_data === expv)) begin
         bad++; $display("FAIL rd_rsp: addr %0d got valid=%b data=%h want 1 %h", a, rd_rsp_valid, rd_rsp_data, expv);
      end
      @(negedge clk);
      total++; if (rd_rsp_valid !== 1'b0) begin bad++; $display("FAIL rd_pulse_len: addr %0d got valid %b want 0", a, rd_rsp_valid); end
   endtask

   task automatic test_capture_random();
      logic [AW-1:0] a;
      for (int i = 0; i < 20; i++) begin
         a = AW'($urandom_range(700, 100));
         do_write(a, DW'($urandom), 1'b0);
      end
      for (int i = 0; i < 3; i++) begin
         a = AW'($urandom_range(700, 100));
         do_read(a, exp_frame[a]);
      end
   endtask

   task automatic test_priority();
      logic [AW-1:0] wa [3];
      logic [DW-1:0] wd [3];
      @(negedge clk);
      rd_req_valid = 1'b1; rd_req_addr = 10'd300;
      for (int i = 0; i < 3; i++) begin
         if (i > 0) begin
            @(negedge clk);
            total++;
            if (!(bram_we === 1'b1 && bram_addr === wa[i-1] && bram_din === wd[i-1])) begin
               bad++; $display("FAIL prio_write: got we=%b addr=%0d din=%h want 1 %0d %h", bram_we, bram_addr, bram_din, wa[i-1], wd[i-1]);
            end
         end
         wa[i] = AW'($urandom_range(700, 100));
         wd[i] = DW'($urandom);
         cap_wr_valid = 1'b1; cap_wr_addr = wa[i]; cap_wr_data = wd[i];
         #1;
         total++; if (rd_req_ready !== 1'b0) begin bad++; $display("FAIL prio_stall: cycle %0d got rd_req_ready=%b want 0", i, rd_req_ready); end
         @(posedge clk);
         exp_frame[wa[i]] = wd[i];
      end
      @(negedge clk);
      total++;
      if (!(bram_we === 1'b1 && bram_addr === wa[2])) begin
         bad++; $display("FAIL prio_write_last: got we=%b addr=%0d want 1 %0d", bram_we, bram_addr, wa[2]);
      end
      cap_wr_valid = 1'b0;
      #1;
      total++; if (rd_req_ready !== 1'b1) begin bad++; $display("FAIL prio_release: got rd_req_ready=%b want 1", rd_req_ready); end
      @(posedge clk);
      @(negedge clk);
      rd_req_valid = 1'b0;
      total++;
      if (!(bram_en === 1'b1 && bram_we === 1'b0 && bram_addr === 10'd300)) begin
         bad++; $display("FAIL prio_read_issue: got en=%b we=%b addr=%0d want 1 0 300", bram_en, bram_we, bram_addr);
      end
      @(negedge clk);
      @(negedge clk);
      total++;
      if (!(rd_rsp_valid === 1'b1 && rd_rsp_data === exp_frame[300])) begin
         bad++; $display("FAIL prio_read_rsp: got valid=%b data=%h want 1 %h", rd_rsp_valid, rd_rsp_data, exp_frame[300]);
      end
   endtask

   task automatic test_oob();
      int n;
      int exp_oob;
      n = 300;
      for (int i = 0; i <= n; i++) begin
         @(negedge clk);
         if (i > 0) begin
            total++; if (bram_en !== 1'b0) begin bad++; $display("FAIL oob_bram_en: write %0d got %b want 0", i - 1, bram_en); end
         end
         if (i == 100) begin
            total++; if (oob_count !== 8'd100) begin bad++; $display("FAIL oob_count_mid: got %0d want 100", oob_count); end
         end
         if (i < n) begin
            cap_wr_valid = 1'b1;
            cap_wr_addr  = (i % 2 == 1) ? 10'd1023 : 10'd784;
            cap_wr_data  = DW'($urandom);
         end else begin
            cap_wr_valid = 1'b0;
         end
      end
      exp_oob = (n > 255) ? 255 : n;
      total++; if (int'(oob_count) != exp_oob) begin bad++; $display("FAIL oob_count_sat: got %0d want %0d", oob_count, exp_oob); end
   endtask

   task automatic test_frame_done();
      do_write(10'd5, 16'h00FF, 1'b0);
      do_write(10'd783, 16'hFFFF, 1'b0);
      total++; if (frame_ready !== 1'b0) begin bad++; $display("FAIL pre_done_ready: got %b want 0", frame_ready); end
      do_write(10'd10, 16'h0A0A, 1'b1);
      total++; if ({frame_ready, busy, cap_wr_ready, rd_req_ready} !== 4'b1001) begin
         bad++; $display("FAIL done_state: got ready/busy/cap/rd=%b want 1001", {frame_ready, busy, cap_wr_ready, rd_req_ready});
      end
   endtask

   task automatic test_readback();
      do_read(10'd5,   16'h00FF);
      do_read(10'd10,  16'h0A0A);
      do_read(10'd783, 16'hFFFF);
      do_read(10'd6,   16'h0000);
      do_read(10'd900, 16'h0000);
   endtask

   task automatic test_back_to_back();
      logic [AW-1:0] req [$];
      logic [AW-1:0] a;
      logic [DW-1:0] expv;
      int nreq;
      for (int i = 0; i < DEPTH; i++) req.push_back(AW'(i));
      req.push_back(10'd900);
      nreq = req.size();
      for (int c = 0; c < nreq + 4; c++) begin
         @(negedge clk);
         total++;
         if (c >= 3 && c - 3 < nreq) begin
            a = req[c-3];
            expv = (int'(a) < DEPTH) ? exp_frame[a] : '0;
            if (!(rd_rsp_valid === 1'b1 && rd_rsp_data === expv)) begin
               bad++; $display("FAIL b2b_rsp: addr %0d got valid=%b data=%h want 1 %h", a, rd_rsp_valid, rd_rsp_data, expv);
            end
         end else if (rd_rsp_valid !== 1'b0) begin
            bad++; $display("FAIL b2b_idle: slot %0d got valid %b want 0", c, rd_rsp_valid);
         end
         if (c < nreq) begin
            rd_req_valid = 1'b1; rd_req_addr = req[c];
            #1;
            total++; if (rd_req_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready: slot %0d got %b want 1", c, rd_req_ready); end
         end else begin
            rd_req_valid = 1'b0;
         end
      end
   endtask

   task automatic test_random_reads();
      logic [AW-1:0] a;
      for (int i = 0; i < 6; i++) begin
         a = AW'($urandom_range(1023, 0));
         do_read(a, (int'(a) < DEPTH) ? exp_frame[a] : '0);
      end
   endtask

   task automatic test_restart_and_reset();
      @(negedge clk);
      take_photo = 1'b1; rd_req_valid = 1'b1; rd_req_addr = 10'd783;
      #1;
      total++; if (rd_req_ready !== 1'b1) begin bad++; $display("FAIL restart_rd_ready: got %b want 1", rd_req_ready); end
      @(posedge clk);
      @(negedge clk);
      rd_req_valid = 1'b0;
      total++; if ({busy, frame_ready, rd_req_ready} !== 3'b100) begin bad++; $display("FAIL restart_state: got busy/ready/rd=%b want 100", {busy, frame_ready, rd_req_ready}); end
      total++; if (oob_count !== 8'd0) begin bad++; $display("FAIL restart_oob_clear: got %0d want 0", oob_count); end
      total++; if (!(bram_en === 1'b1 && bram_we === 1'b0 && bram_addr === 10'd783)) begin
         bad++; $display("FAIL restart_read_issue: got en=%b we=%b addr=%0d want 1 0 783", bram_en, bram_we, bram_addr);
      end
      @(negedge clk);
      total++; if (!(bram_we === 1'b1 && bram_addr === 10'd0 && rd_rsp_valid === 1'b0)) begin
         bad++; $display("FAIL restart_clear0: got we=%b addr=%0d rsp=%b want 1 0 0", bram_we, bram_addr, rd_rsp_valid);
      end
      @(negedge clk);
      total++; if (!(rd_rsp_valid === 1'b1 && rd_rsp_data === 16'hFFFF)) begin
         bad++; $display("FAIL inflight_rsp: got valid=%b data=%h want 1 ffff", rd_rsp_valid, rd_rsp_data);
      end
      total++; if (!(bram_we === 1'b1 && bram_addr === 10'd1)) begin bad++; $display("FAIL restart_clear1: got we=%b addr=%0d want 1 1", bram_we, bram_addr); end
      follow_clear(2, 400, 1'b0);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      total++; if ({bram_en, bram_we} !== 2'b00) begin bad++; $display("FAIL midclear_rst_bram: got en/we=%b want 00", {bram_en, bram_we}); end
      total++; if ({busy, cap_wr_ready, rd_req_ready} !== 3'b000) begin bad++; $display("FAIL midclear_rst_ctrl: got busy/cap/rd=%b want 000", {busy, cap_wr_ready, rd_req_ready}); end
      take_photo = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      total++; if ({busy, rd_req_ready, bram_en} !== 3'b010) begin bad++; $display("FAIL post_rst_idle: got busy/rd/en=%b want 010", {busy, rd_req_ready, bram_en}); end
      take_photo = 1'b1;
      @(posedge clk);
      @(negedge clk);
      total++; if ({busy, bram_we} !== 2'b10) begin bad++; $display("FAIL reclear_entry: got busy/we=%b want 10", {busy, bram_we}); end
      follow_clear(0, DEPTH - 1, 1'b0);
      @(negedge clk);
      total++; if ({cap_wr_ready, bram_we} !== 2'b10) begin bad++; $display("FAIL reclear_capture: got cap/we=%b want 10", {cap_wr_ready, bram_we}); end
      take_photo = 1'b0;
   endtask

   initial begin
      total = 0;
      bad   = 0;
      test_reset();
      test_clear();
      test_capture_random();
      test_priority();
      test_oob();
      test_frame_done();
      test_readback();
      test_back_to_back();
      test_random_reads();
      test_restart_and_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/frame_buffer_scheduler.md
# frame_buffer_scheduler

Owns the single-port 784×16 frame BRAM that holds the 28×28 digit image. It sequences the frame lifecycle: clear, then capture, then ready for readout. It also arbitrates BRAM access between the internal clear engine, the camera downsampler's write stream and the classifier/debug read stream. It sits between the camera pipeline, the inference front-end and the frame BRAM, and is the only block that drives the BRAM port.

## Interface
- DEPTH, 784, number of valid pixel words; addresses 0..DEPTH-1
- ADDR_W, 10, BRAM address width
- DATA_W, 16, pixel word width
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- take_photo  in  1  level request; its rising edge starts a new frame
- frame_done  in  1  one-cycle pulse from the camera at end of frame
- busy  out  1  high in CLEAR and CAPTURE
- frame_ready  out  1  high in READY
- cap_wr_valid  in  1  capture write request
- cap_wr_addr  in  ADDR_W  capture pixel address
- cap_wr_data  in  DATA_W  capture pixel value
- cap_wr_ready  out  1  capture write accepted when valid&ready
- rd_req_valid  in  1  read request
- rd_req_addr  in  ADDR_W  read address
- rd_req_ready  out  1  read accepted when valid&ready
- rd_rsp_valid  out  1  one-cycle pulse with read data
- rd_rsp_data  out  DATA_W  read data
- oob_count  out  8  saturating count of dropped out-of-range capture writes
- bram_en, bram_we  out  1  BRAM port enable and write enable
- bram_addr  out  ADDR_W  BRAM address
- bram_din  out  DATA_W  BRAM write data
- bram_dout  in  DATA_W  BRAM read data, valid 1 cycle after an enabled read

## Operation
- States: IDLE, CLEAR, CAPTURE, READY.
- take_photo is edge-detected against a registered copy. The registered copy resets to 0.
- IDLE: a take_photo rising edge moves to CLEAR with clear_addr=0.
- READY: a take_photo rising edge also moves to CLEAR with clear_addr=0.
- CLEAR: writes 0 to addresses 0..DEPTH-1, one per cycle, in ascending order. After issuing address DEPTH-1 it moves to CAPTURE. Both requesters see ready=0.
- CAPTURE:
  - cap_wr_ready=1.
  - rd_req_ready = !cap_wr_valid, so the writer has strict priority.
  - frame_done moves to READY. A write accepted in the same cycle as frame_done is still performed.
- READY and IDLE: cap_wr_ready=0 and rd_req_ready=1.
- take_photo edges in CLEAR or CAPTURE are ignored.
- frame_done outside CAPTURE is ignored.
- Out-of-range capture write (addr ≥ DEPTH):
  - Accepted, but no BRAM access.
  - oob_count increments and saturates at 255.
  - oob_count clears on entry to CLEAR.
- Out-of-range read (addr ≥ DEPTH): accepted, no BRAM access, and the response returns 0 with normal latency.
- At most one BRAM access per cycle. The arbitration rules above guarantee this.
- The read response pipeline is independent of state changes. A read accepted just before leaving READY still delivers its response.

## Timing
- Reset values:
  - State is IDLE.
  - busy, frame_ready, cap_wr_ready, rd_req_ready, rd_rsp_valid, bram_en and bram_we are 0.
  - bram_addr, bram_din, rd_rsp_data and oob_count are 0.
  - Outputs take these values immediately on rst_n low, including mid-CLEAR and mid-read.
- BRAM outputs are registered. A request accepted at edge N drives bram_* during cycle N..N+1.
- Read latency: rd_rsp_valid is high for exactly the cycle following edge N+2. Back-to-back reads sustain one response per cycle.
- CLEAR:
  - Entered at edge E, so busy is high from E.
  - bram_we is high for exactly DEPTH consecutive cycles starting after E+1.
  - cap_wr_ready rises after edge E+DEPTH.
- frame_ready rises the cycle after the edge where frame_done is sampled in CAPTURE.
- Ready signals are combinational from state and cap_wr_valid. Everything else is registered.

## Test plan
- Reset, then pulse take_photo -> busy=1; 784 consecutive zero writes to addresses 0..783; then CAPTURE with cap_wr_ready=1. A second take_photo edge during CLEAR is ignored.
- In CAPTURE, write addr 5=0x00FF and addr 783=0xFFFF; pulse frame_done together with a write to addr 10=0x0A0A -> frame_ready=1. Reads of 5, 10, 783 and 6 return 0x00FF, 0x0A0A, 0xFFFF and 0x0000, each rd_rsp_valid pulse 2 edges after acceptance.
- In CAPTURE, assert cap_wr_valid and rd_req_valid together for 3 cycles, then drop cap_wr_valid -> the read is stalled (rd_req_ready=0) for 3 cycles and is accepted on cycle 4. bram_en never shows two accesses in one cycle.
- Capture writes to addr 784 and 1023, 300 times in total -> no BRAM enable for them and oob_count=255. The next take_photo clears oob_count to 0.
- In READY, issue back-to-back reads of 0..783 -> 784 responses on consecutive cycles, data matching the captured frame. A read of addr 900 returns 0.
- Assert rst_n low in the middle of CLEAR (at clear_addr≈400) -> bram_en/bram_we drop to 0 immediately and the state is IDLE. After release, a new take_photo edge restarts the clear from address 0.
